// File: rtl/arp_pkg.sv
// ARP transmit/receive shared constants: header field values, frame
// lengths, FSM state encoding and the 28-byte payload builder.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE       = 16'h0001;
    localparam logic [15:0] ARP_PTYPE       = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam logic [15:0] ARP_OP_REQ      = 16'h0001;
    localparam logic [15:0] ARP_OP_REP      = 16'h0002;
    localparam int          ARP_LEN         = 28;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam int          ARP_BITS        = ARP_LEN * 8;
    localparam logic [47:0] MAC_BCAST       = 48'hFFFF_FFFF_FFFF;

    // Transmit FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // Packs the ARP payload in wire order (first byte in the MSBs)
    function automatic logic [ARP_BITS-1:0] arp_build(
        input logic [15:0] op,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        return {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, op, sha, spa, tha, tpa};
    endfunction

endpackage

// File: rtl/arp_tx_if.sv
// Byte-wide valid/ready stream between the ARP transmitter and the MAC tx layer.
interface arp_tx_if;
    logic [7:0] mac_data;
    logic       mac_last;
    logic       mac_valid;
    logic       mac_ready;

    modport master (output mac_data, output mac_last, output mac_valid, input mac_ready);
    modport slave  (input mac_data, input mac_last, input mac_valid, output mac_ready);
endinterface

// File: rtl/arp_tx.sv
// ARP transmitter: serialises 28-byte ARP request/reply payloads (optionally
// zero-padded to 46 bytes) MSB-first onto a byte stream.
module arp_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] P_SOURCE_MAC = 48'h00_00_00_00_00_00,
    parameter logic [31:0] P_SOURCE_IP  = {8'd192, 8'd168, 8'd1, 8'd2},
    parameter logic [31:0] P_TARGET_IP  = {8'd192, 8'd168, 8'd1, 8'd1},
    parameter bit          P_PAD_EN     = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_source_ip,
    input  logic        i_s_ip_valid,
    input  logic [31:0] i_target_ip,
    input  logic        i_t_ip_valid,
    input  logic        i_send_req,
    input  logic        i_send_reply,
    input  logic [47:0] i_reply_mac,
    input  logic [31:0] i_reply_ip,
    arp_tx_if.master    mac,
    output logic [47:0] o_dst_mac,
    output logic        o_busy
);

    localparam int         LAST_N   = P_PAD_EN ? ETH_MIN_PAYLOAD : ARP_LEN;
    localparam logic [5:0] LAST_IDX = 6'(LAST_N - 1);

    logic [1:0]          state_q,    state_d;
    logic                kind_rep_q, kind_rep_d;
    logic [31:0]         src_ip_q,   src_ip_d;
    logic [31:0]         tgt_ip_q,   tgt_ip_d;
    logic                pend_req_q, pend_req_d;
    logic                pend_rep_q, pend_rep_d;
    logic [47:0]         rep_mac_q,  rep_mac_d;
    logic [31:0]         rep_ip_q,   rep_ip_d;
    logic [31:0]         cur_ip_q,   cur_ip_d;
    logic [47:0]         dst_mac_q,  dst_mac_d;
    logic [ARP_BITS-1:0] shreg_q,    shreg_d;
    logic [5:0]          cnt_q,      cnt_d;
    logic                is_last;

    assign is_last = (cnt_q == LAST_IDX);

    // Next-state: config updates, trigger capture, FSM and shift/count datapath
    always_comb begin
        state_d    = state_q;
        kind_rep_d = kind_rep_q;
        src_ip_d   = src_ip_q;
        tgt_ip_d   = tgt_ip_q;
        pend_req_d = pend_req_q;
        pend_rep_d = pend_rep_q;
        rep_mac_d  = rep_mac_q;
        rep_ip_d   = rep_ip_q;
        cur_ip_d   = cur_ip_q;
        dst_mac_d  = dst_mac_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;

        if (i_s_ip_valid) src_ip_d = i_source_ip;
        if (i_t_ip_valid) tgt_ip_d = i_target_ip;

        case (state_q)
            ST_IDLE: begin
                // Peer address is copied out of the reply buffer here so that a
                // newer reply landing during LOAD cannot split dst MAC from payload.
                if (pend_rep_q) begin
                    state_d    = ST_LOAD;
                    kind_rep_d = 1'b1;
                    pend_rep_d = 1'b0;
                    dst_mac_d  = rep_mac_q;
                    cur_ip_d   = rep_ip_q;
                end else if (pend_req_q) begin
                    state_d    = ST_LOAD;
                    kind_rep_d = 1'b0;
                    pend_req_d = 1'b0;
                    dst_mac_d  = MAC_BCAST;
                end
            end
            ST_LOAD: begin
                shreg_d = arp_build(kind_rep_q ? ARP_OP_REP : ARP_OP_REQ,
                                    P_SOURCE_MAC,
                                    src_ip_q,
                                    kind_rep_q ? dst_mac_q : 48'h0,
                                    kind_rep_q ? cur_ip_q : tgt_ip_q);
                cnt_d   = 6'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Zeros shift in behind the payload, which supplies the pad bytes.
                if (mac.mac_ready) begin
                    shreg_d = shreg_q << 8;
                    cnt_d   = cnt_q + 6'd1;
                    if (is_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // New triggers win over the clear of a flag being served this cycle.
        if (i_send_req) pend_req_d = 1'b1;
        if (i_send_reply) begin
            pend_rep_d = 1'b1;
            rep_mac_d  = i_reply_mac;
            rep_ip_d   = i_reply_ip;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            kind_rep_q <= 1'b0;
            src_ip_q   <= P_SOURCE_IP;
            tgt_ip_q   <= P_TARGET_IP;
            pend_req_q <= 1'b0;
            pend_rep_q <= 1'b0;
            rep_mac_q  <= 48'h0;
            rep_ip_q   <= 32'h0;
            cur_ip_q   <= 32'h0;
            dst_mac_q  <= 48'h0;
            shreg_q    <= '0;
            cnt_q      <= 6'd0;
        end else begin
            state_q    <= state_d;
            kind_rep_q <= kind_rep_d;
            src_ip_q   <= src_ip_d;
            tgt_ip_q   <= tgt_ip_d;
            pend_req_q <= pend_req_d;
            pend_rep_q <= pend_rep_d;
            rep_mac_q  <= rep_mac_d;
            rep_ip_q   <= rep_ip_d;
            cur_ip_q   <= cur_ip_d;
            dst_mac_q  <= dst_mac_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mac.mac_data  = shreg_q[ARP_BITS-1 -: 8];
    assign mac.mac_valid = (state_q == ST_SEND);
    assign mac.mac_last  = (state_q == ST_SEND) && is_last;
    assign o_dst_mac     = dst_mac_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arp_tx.sv
// Directed testbench for arp_tx: default and padded builds side by side.
module tb_arp_tx;

    logic        clk;
    logic        rst_n;
    logic [31:0] source_ip;
    logic        s_ip_valid;
    logic [31:0] target_ip;
    logic        t_ip_valid;
    logic        send_req;
    logic        send_reply;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip;
    logic [47:0] dst_mac;
    logic        busy;
    logic        pad_req;
    logic [47:0] pad_dst;
    logic        pad_busy;

    int compared;
    int mismatched;

    logic [7:0]  cap [0:63];
    int          cap_n;
    int          cap_last;
    int          cap_hold_err;
    bit          cap_to;
    logic [47:0] cap_dst;

    arp_tx_if mif ();
    arp_tx_if pif ();

    arp_tx dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_source_ip(source_ip), .i_s_ip_valid(s_ip_valid),
        .i_target_ip(target_ip), .i_t_ip_valid(t_ip_valid),
        .i_send_req(send_req), .i_send_reply(send_reply),
        .i_reply_mac(reply_mac), .i_reply_ip(reply_ip),
        .mac(mif.master), .o_dst_mac(dst_mac), .o_busy(busy)
    );

    arp_tx #(.P_PAD_EN(1'b1)) dut_pad (
        .i_clk(clk), .i_rst(rst_n),
        .i_source_ip(32'h0), .i_s_ip_valid(1'b0),
        .i_target_ip(32'h0), .i_t_ip_valid(1'b0),
        .i_send_req(pad_req), .i_send_reply(1'b0),
        .i_reply_mac(48'h0), .i_reply_ip(32'h0),
        .mac(pif.master), .o_dst_mac(pad_dst), .o_busy(pad_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [223:0] exp_vec(input bit rep, input logic [47:0] tha, input logic [31:0] tpa);
        return {16'h0001, 16'h0800, 8'h06, 8'h04, rep ? 16'h0002 : 16'h0001,
                48'h0, 32'hC0A8_0102, tha, tpa};
    endfunction

    // Index of first captured byte differing from v (zero beyond byte 28), or -1
    function automatic int first_diff(input logic [223:0] v, input int len);
        logic [7:0] e;
        for (int i = 0; i < len; i++) begin
            e = (i < 28) ? v[223 - 8*i -: 8] : 8'h00;
            if (cap[i] !== e) return i;
        end
        return -1;
    endfunction

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    task automatic pulse_reply(input logic [47:0] m, input logic [31:0] ip);
        reply_mac  = m;
        reply_ip   = ip;
        send_reply = 1'b1;
        @(negedge clk);
        send_reply = 1'b0;
    endtask

    // Captures one packet; optional ready pattern 1,0,0,1 and a target-IP
    // update issued once inj_at bytes have been accepted.
    task automatic collect(input bit pad, input bit bp, input int inj_at, input logic [31:0] inj_ip);
        int k;
        bit done, injected, holding, rdy;
        logic [7:0] hd, cd;
        logic hl, cl, cv;
        cap_n = 0; cap_last = 0; cap_hold_err = 0; cap_to = 0; cap_dst = 48'h0;
        injected = 0; holding = 0; done = 0; hd = 8'h0; hl = 1'b0;
        k = 0;
        while (!(pad ? pif.mac_valid : mif.mac_valid)) begin
            if (k >= 20) begin
                cap_to = 1;
                return;
            end
            @(negedge clk);
            k++;
        end
        cap_dst = pad ? pad_dst : dst_mac;
        k = 0;
        while (!done) begin
            cd = pad ? pif.mac_data : mif.mac_data;
            cl = pad ? pif.mac_last : mif.mac_last;
            cv = pad ? pif.mac_valid : mif.mac_valid;
            if (holding && (cd !== hd || cl !== hl || cv !== 1'b1)) cap_hold_err++;
            t_ip_valid = 1'b0;
            if (inj_at >= 0 && !injected && cap_n == inj_at) begin
                target_ip  = inj_ip;
                t_ip_valid = 1'b1;
                injected   = 1;
            end
            rdy = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (pad) pif.mac_ready = rdy; else mif.mac_ready = rdy;
            holding = 0;
            if (cv !== 1'b1) begin
                cap_to = 1;
                done = 1;
            end else if (rdy) begin
                cap[cap_n] = cd;
                cap_n++;
                if (cl === 1'b1) begin
                    cap_last = cap_n;
                    done = 1;
                end else if (cap_n >= 64) begin
                    done = 1;
                end
            end else begin
                holding = 1;
                hd = cd;
                hl = cl;
            end
            k++;
            if (k > 300) begin
                cap_to = 1;
                done = 1;
            end
            @(negedge clk);
        end
        t_ip_valid    = 1'b0;
        mif.mac_ready = 1'b1;
        pif.mac_ready = 1'b1;
    endtask

    task automatic test_reset();
        compared++;
        if (mif.mac_valid !== 1'b0 || mif.mac_last !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: valid=%b last=%b busy=%b required 0/0/0", mif.mac_valid, mif.mac_last, busy);
        end
        compared++;
        if (dst_mac !== 48'h0 || mif.mac_data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_data: dst=%h data=%h required 0/0", dst_mac, mif.mac_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || mif.mac_valid !== 1'b0 || pad_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: busy=%b valid=%b pad_busy=%b required 0", busy, mif.mac_valid, pad_busy);
        end
    endtask

    task automatic test_request();
        logic [7:0] t1 [0:27];
        int bad;
        t1 = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hC0, 8'hA8, 8'h01, 8'h02,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'hC0, 8'hA8, 8'h01, 8'h01};
        pulse_req();
        compared++;
        if (mif.mac_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_lat_n1: valid=%b required 0", mif.mac_valid);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || mif.mac_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_load: busy=%b valid=%b required 1/0", busy, mif.mac_valid);
        end
        @(negedge clk);
        compared++;
        if (mif.mac_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL t1_lat_n2: valid=%b required 1", mif.mac_valid);
        end
        collect(0, 0, -1, 32'h0);
        bad = -1;
        for (int i = 0; i < 28; i++) if (bad < 0 && cap[i] !== t1[i]) bad = i;
        compared++;
        if (cap_to || cap_n != 28 || cap_last != 28 || bad != -1) begin
            mismatched++;
            $display("FAIL t1_bytes: n=%0d last=%0d first_bad=%0d timeout=%0b required 28/28/-1/0", cap_n, cap_last, bad, cap_to);
        end
        compared++;
        if (cap_dst !== 48'hFFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL t1_dst: dst=%h required ffffffffffff", cap_dst);
        end
        compared++;
        if (mif.mac_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_end: valid=%b busy=%b required 0/0", mif.mac_valid, busy);
        end
    endtask

    task automatic test_reply();
        int d;
        pulse_reply(48'h11_22_33_44_55_66, 32'hC0A8_0109);
        collect(0, 0, -1, 32'h0);
        d = first_diff(exp_vec(1, 48'h11_22_33_44_55_66, 32'hC0A8_0109), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1) begin
            mismatched++;
            $display("FAIL t2_bytes: last=%0d first_bad=%0d timeout=%0b required 28/-1/0", cap_last, d, cap_to);
        end
        compared++;
        if (cap_dst !== 48'h11_22_33_44_55_66) begin
            mismatched++;
            $display("FAIL t2_dst: dst=%h required 112233445566", cap_dst);
        end
    endtask

    task automatic test_backpressure();
        int d;
        pulse_req();
        collect(0, 1, -1, 32'h0);
        d = first_diff(exp_vec(0, 48'h0, 32'hC0A8_0101), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1) begin
            mismatched++;
            $display("FAIL t3_bytes: last=%0d first_bad=%0d timeout=%0b required 28/-1/0", cap_last, d, cap_to);
        end
        compared++;
        if (cap_hold_err != 0) begin
            mismatched++;
            $display("FAIL t3_hold: unstable stall cycles=%0d required 0", cap_hold_err);
        end
    endtask

    task automatic test_back_to_back();
        int d, extra;
        reply_mac  = 48'hA0_B0_C0_D0_E0_F0;
        reply_ip   = 32'h0A01_0203;
        send_reply = 1'b1;
        send_req   = 1'b1;
        @(negedge clk);
        send_reply = 1'b0;
        send_req   = 1'b0;
        collect(0, 0, -1, 32'h0);
        d = first_diff(exp_vec(1, 48'hA0_B0_C0_D0_E0_F0, 32'h0A01_0203), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1 || cap_dst !== 48'hA0_B0_C0_D0_E0_F0) begin
            mismatched++;
            $display("FAIL t4_first_reply: last=%0d first_bad=%0d dst=%h required 28/-1/a0b0c0d0e0f0", cap_last, d, cap_dst);
        end
        collect(0, 0, -1, 32'h0);
        d = first_diff(exp_vec(0, 48'h0, 32'hC0A8_0101), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1 || cap_dst !== 48'hFFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL t4_second_req: last=%0d first_bad=%0d dst=%h timeout=%0b required 28/-1/ffffffffffff/0", cap_last, d, cap_dst, cap_to);
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (mif.mac_valid === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        compared++;
        if (extra != 0) begin
            mismatched++;
            $display("FAIL t4_no_extra: active cycles=%0d required 0", extra);
        end
    endtask

    task automatic test_config_mid();
        int d;
        pulse_req();
        collect(0, 0, 10, 32'h0A00_0001);
        d = first_diff(exp_vec(0, 48'h0, 32'hC0A8_0101), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1) begin
            mismatched++;
            $display("FAIL t5_current: last=%0d first_bad=%0d required 28/-1", cap_last, d);
        end
        pulse_req();
        collect(0, 0, -1, 32'h0);
        d = first_diff(exp_vec(0, 48'h0, 32'h0A00_0001), 28);
        compared++;
        if (cap_to || cap_last != 28 || d != -1) begin
            mismatched++;
            $display("FAIL t5_next: last=%0d first_bad=%0d byte=%h required 28/-1", cap_last, d, cap[27]);
        end
    endtask

    task automatic test_pad();
        int d;
        pad_req = 1'b1;
        @(negedge clk);
        pad_req = 1'b0;
        collect(1, 0, -1, 32'h0);
        d = first_diff(exp_vec(0, 48'h0, 32'hC0A8_0101), 46);
        compared++;
        if (cap_to || cap_n != 46 || cap_last != 46 || d != -1) begin
            mismatched++;
            $display("FAIL t5_pad: n=%0d last=%0d first_bad=%0d required 46/46/-1", cap_n, cap_last, d);
        end
    endtask

    task automatic test_reset_mid();
        int n, k, d;
        pulse_req();
        n = 0;
        k = 0;
        while (n < 10 && k < 60) begin
            if (mif.mac_valid === 1'b1) n++;
            @(negedge clk);
            k++;
        end
        compared++;
        if (n != 10) begin
            mismatched++;
            $display("FAIL t6_reach: bytes=%0d required 10", n);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (mif.mac_valid !== 1'b0 || mif.mac_last !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL t6_abort: valid=%b last=%b busy=%b required 0/0/0", mif.mac_valid, mif.mac_last, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_req();
        collect(0, 0, -1, 32'h0);
        d = first_diff(exp_vec(0, 48'h0, 32'hC0A8_0101), 28);
        compared++;
        if (cap_to || cap_n != 28 || cap_last != 28 || d != -1 || cap_dst !== 48'hFFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL t6_clean: n=%0d last=%0d first_bad=%0d dst=%h required 28/28/-1/ffffffffffff", cap_n, cap_last, d, cap_dst);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        source_ip     = 32'h0;
        s_ip_valid    = 1'b0;
        target_ip     = 32'h0;
        t_ip_valid    = 1'b0;
        send_req      = 1'b0;
        send_reply    = 1'b0;
        reply_mac     = 48'h0;
        reply_ip      = 32'h0;
        pad_req       = 1'b0;
        mif.mac_ready = 1'b1;
        pif.mac_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_request();
        test_reply();
        test_backpressure();
        test_back_to_back();
        test_config_mid();
        test_pad();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
